mrd_col_solver: RTL
===================

# mrd_col_solver

Sequential, parametrised minimal-residual (MR) solver for one column m_j of a sparse approximate inverse M ≈ A⁻¹. Each iteration computes r = e − A·m, q = A·r, α = (r·q)/(q·q) and m ← m + α·r. It adds a start/busy/done handshake, a runtime iteration count, a serial divider for α, saturating fixed-point arithmetic and early exit on a zero denominator. The top-level inverse engine instantiates one per column lane.

## Interface
- DIMENSION, 16, vector length and matrix order
- WIDTH, 16, signed element width
- FRAC, 8, fractional bits; all elements are two's-complement Q(WIDTH−FRAC).FRAC
- MAX_ITER, 4, largest accepted iter_num
- Derived: ACCW = 2*WIDTH+$clog2(DIMENSION); IW = $clog2(MAX_ITER+1); DIVC = ACCW+FRAC

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  clock enable; low freezes all state, including outputs
- start  in  1  request; accepted only in IDLE
- iter_num  in  IW  iteration count, sampled at start; values above MAX_ITER are clamped
- a_mat  in  DIMENSION*DIMENSION*WIDTH  element (k,i) at [(k*DIMENSION+i)*WIDTH +: WIDTH]; must stay stable while busy
- m_init  in  DIMENSION*WIDTH  initial column, sampled at start
- e_vec  in  DIMENSION*WIDTH  right-hand side (normally e_j), sampled at start
- busy  out  1  high from the accept edge until done
- done  out  1  one-cycle pulse
- m_out  out  DIMENSION*WIDTH  working column register
- iter_cnt  out  IW  completed iterations
- zero_den  out  1  run ended on q·q = 0; held until next start
- rnorm  out  ACCW  r·r of the last computed residual, raw Q·2FRAC

## Operation
- FSM states: IDLE → AM → AR → DIV → UPD → (AM | FIN) → IDLE.
- IDLE: on start, latch m_init into m_out, e_vec, and min(iter_num, MAX_ITER). Clear iter_cnt, zero_den and rnorm. Go to AM, or to FIN if the count is 0.
- AM: row counter k = 0..DIMENSION−1, one row per cycle.
  - r_k = sat(e_k − (Σ_i a_ki·m_i) >>> FRAC).
  - Accumulate rr += r_k².
- AR: k = 0..DIMENSION−1.
  - q_k = sat((Σ_i a_ki·r_i) >>> FRAC).
  - Accumulate num += r_k·q_k and den += q_k².
  - At exit: rnorm ← rr. If den = 0, set zero_den and go to FIN.
- DIV: restoring divider, one quotient bit per cycle for DIVC cycles, computing |num|<<FRAC / |den|.
  - Quotient truncates toward zero.
  - Sign applied afterwards = sign(num).
  - α = sat to WIDTH.
- UPD: all i in parallel, m_i ← sat(m_i + (α·r_i) >>> FRAC); then iter_cnt += 1. Go to AM if iter_cnt < count, else FIN.
- FIN: done = 1 and busy = 0 in this cycle; return to IDLE.
- Arithmetic rules:
  - Products are full 2*WIDTH; sums are ACCW wide.
  - >>> is an arithmetic shift (floor).
  - sat clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - rr, num and den never saturate.
- Boundary conditions:
  - start while busy is ignored.
  - start held high in IDLE is accepted once per run; a new run begins the cycle after FIN.
  - en low in any state stalls exactly, with no lost cycles.
  - Reset at any time clears state immediately.

## Timing
- Reset values: busy 0, done 0, m_out 0, iter_cnt 0, zero_den 0, rnorm 0; FSM in IDLE.
- Accept edge is t. busy = 1 from t+1.
- Per-iteration cost T = 2*DIMENSION + DIVC + 1 cycles; defaults give 16+16+44+1 = 77.
- done at t + 1 + N*T (N = clamped count); N = 0 gives done at t+1.
- Zero-denominator exit: done at t + 1 + (completed)*T + 2*DIMENSION.
- m_out changes only on the accept edge and on UPD edges.

## Structure
- Package mrd_pkg holds:
  - the sat function and ACCW/IW/DIVC derivations;
  - the FSM state enum (IDLE, AM, AR, DIV, UPD, FIN).
- Sub-module mrd_row_dot: combinational DIMENSION-wide dot product of row k with a vector, returning a full-precision ACCW result. One instance is shared by AM and AR via a vector mux.
- Divider stays inline in mrd_col_solver.

## Test plan
- **Identity, one iteration:** A = I (diagonal 256), e = e_0, m_init = 0, N = 1 → m_out[0] = 256, others 0; rnorm = 65536; done 78 cycles after accept.
- **Double identity, zero-denominator exit:** A = 2I (512), e = e_0, m_init = 0, N = 2.
  - Iteration 1: α = 128, m_out[0] = 128.
  - Iteration 2: r = 0 → zero_den = 1, iter_cnt = 1, done at 1+77+32 = 110 cycles.
- **Zero iterations:** iter_num = 0, m_init[3] = −77 → done at t+1, m_out = m_init, iter_cnt = 0.
- **Saturation:** A = I with raw diagonal 1, e = e_0 (256), N = 1 → q_0 = 1, α saturates to 32767, m_out[0] = 32767.
- **Handshake:** start pulses while busy are ignored (no restart, latency unchanged). en low for 10 cycles inside DIV → done 10 cycles later, identical m_out.
- **Reset mid-run:** rst low during AR → busy, done, m_out, iter_cnt and rnorm are 0 asynchronously. A start after release runs normally.

Source files
------------

// File: rtl/mrd_pkg.sv
// Shared FSM state type, width derivations and saturation helper for the
// minimal-residual column solver.
package mrd_pkg;

  typedef enum logic [2:0] {IDLE, AM, AR, DIV, UPD, FIN} state_e;

  function automatic int accw_f(input int dim, input int width);
    return 2 * width + $clog2(dim);
  endfunction

  function automatic int iw_f(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  function automatic int divc_f(input int accw, input int frac);
    return accw + frac;
  endfunction

  // Clamp x into the signed w-bit range; the caller narrows the result to w bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/mrd_row_dot.sv
// Full-precision dot product of one matrix row with a vector, purely combinational.
module mrd_row_dot #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 16,
  parameter int ACCW      = 36
) (
  input  logic [DIMENSION*WIDTH-1:0] row_i,
  input  logic [DIMENSION*WIDTH-1:0] vec_i,
  output logic signed [ACCW-1:0]     dot_o
);

  logic signed [ACCW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      acc = acc + ACCW'($signed(row_i[i*WIDTH +: WIDTH]) * $signed(vec_i[i*WIDTH +: WIDTH]));
    end
    dot_o = acc;
  end

endmodule

// File: rtl/mrd_col_solver.sv
// Sequential minimal-residual solver for one column of a sparse approximate
// inverse: r = e - A*m, q = A*r, alpha = (r.q)/(q.q), m += alpha*r per iteration.
module mrd_col_solver
  import mrd_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int MAX_ITER  = 4,
  localparam int ACCW     = accw_f(DIMENSION, WIDTH),
  localparam int IW       = iw_f(MAX_ITER),
  localparam int DIVC     = divc_f(ACCW, FRAC)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 start,
  input  logic [IW-1:0]                        iter_num,
  input  logic [DIMENSION*DIMENSION*WIDTH-1:0] a_mat,
  input  logic [DIMENSION*WIDTH-1:0]           m_init,
  input  logic [DIMENSION*WIDTH-1:0]           e_vec,
  output logic                                 busy,
  output logic                                 done,
  output logic [DIMENSION*WIDTH-1:0]           m_out,
  output logic [IW-1:0]                        iter_cnt,
  output logic                                 zero_den,
  output logic [ACCW-1:0]                      rnorm,
  output state_e                               fsm_state
);

  localparam int KW = $clog2(DIMENSION);
  localparam int CW = $clog2(DIVC);
  localparam int RW = ACCW + 1;

  // Handshake: start is taken only in IDLE (en high); busy covers AM..UPD and
  // done pulses for the single FIN cycle, after which IDLE may accept again.
  state_e                     state_q, state_d;
  logic [KW-1:0]              k_q;
  logic [DIMENSION*WIDTH-1:0] m_q, e_q, r_q, m_upd;
  logic [IW-1:0]              n_q, it_q, n_clamp, it_inc;
  logic                       zd_q;
  logic signed [ACCW-1:0]     rr_q, num_q, den_q, rr_next, num_next, den_next;
  logic [ACCW-1:0]            rnorm_q, num_abs;
  logic [DIVC-1:0]            dvd_q, quo_q;
  logic [RW-1:0]              rem_q;
  logic [RW:0]                rem_sh, den_u;
  logic                       ge;
  logic [CW-1:0]              dc_q;
  logic                       k_last;
  logic [DIMENSION*WIDTH-1:0] row, vec;
  logic signed [ACCW-1:0]     dot, dot_sh;
  logic signed [WIDTH-1:0]    e_k, r_k, r_new, q_new, alpha;
  logic signed [2*WIDTH-1:0]  rsq, rq, qsq, prod;
  logic signed [63:0]         q64;

  function automatic logic [WIDTH-1:0] sat_n(input logic signed [63:0] x);
    return WIDTH'(sat_w(x, WIDTH));
  endfunction

  assign row = a_mat[k_q*DIMENSION*WIDTH +: DIMENSION*WIDTH];
  assign vec = (state_q == AR) ? r_q : m_q;

  mrd_row_dot #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .ACCW(ACCW)) u_dot (
    .row_i (row),
    .vec_i (vec),
    .dot_o (dot)
  );

  always_comb begin
    dot_sh   = dot >>> FRAC;
    e_k      = $signed(e_q[k_q*WIDTH +: WIDTH]);
    r_k      = $signed(r_q[k_q*WIDTH +: WIDTH]);
    r_new    = sat_n(64'(e_k) - 64'(dot_sh));
    q_new    = sat_n(64'(dot_sh));
    rsq      = r_new * r_new;
    rq       = r_k * q_new;
    qsq      = q_new * q_new;
    rr_next  = rr_q + ACCW'(rsq);
    num_next = num_q + ACCW'(rq);
    den_next = den_q + ACCW'(qsq);
    num_abs  = num_next[ACCW-1] ? ACCW'(-num_next) : ACCW'(num_next);
    k_last   = (k_q == KW'(DIMENSION - 1));
    n_clamp  = (iter_num > IW'(MAX_ITER)) ? IW'(MAX_ITER) : iter_num;
    it_inc   = it_q + IW'(1);
    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    rem_sh   = {rem_q, dvd_q[DIVC-1]};
    den_u    = {2'b00, den_q};
    ge       = (rem_sh >= den_u);
    q64      = $signed(64'(quo_q));
    alpha    = sat_n(num_q[ACCW-1] ? -q64 : q64);
    prod     = '0;
    m_upd    = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      prod = alpha * $signed(r_q[i*WIDTH +: WIDTH]);
      m_upd[i*WIDTH +: WIDTH] = sat_n(64'($signed(m_q[i*WIDTH +: WIDTH])) + 64'(prod >>> FRAC));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (n_clamp == '0) ? FIN : AM;
      AM:   if (k_last) state_d = AR;
      AR:   if (k_last) state_d = (den_next == '0) ? FIN : DIV;
      DIV:  if (dc_q == CW'(DIVC - 1)) state_d = UPD;
      UPD:  state_d = (it_inc < n_q) ? AM : FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= '0; m_q <= '0; e_q <= '0; r_q <= '0; n_q <= '0; it_q <= '0;
      zd_q <= 1'b0; rr_q <= '0; num_q <= '0; den_q <= '0; rnorm_q <= '0;
      dvd_q <= '0; quo_q <= '0; rem_q <= '0; dc_q <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: if (start) begin
          m_q <= m_init; e_q <= e_vec; n_q <= n_clamp; it_q <= '0;
          zd_q <= 1'b0; rnorm_q <= '0; k_q <= '0;
          rr_q <= '0; num_q <= '0; den_q <= '0;
        end
        AM: begin
          r_q[k_q*WIDTH +: WIDTH] <= r_new;
          rr_q <= rr_next;
          k_q  <= k_last ? '0 : k_q + KW'(1);
        end
        AR: begin
          num_q <= num_next;
          den_q <= den_next;
          k_q   <= k_last ? '0 : k_q + KW'(1);
          if (k_last) begin
            rnorm_q <= rr_q;
            zd_q    <= (den_next == '0);
            rem_q   <= '0;
            quo_q   <= '0;
            dc_q    <= '0;
            dvd_q   <= {num_abs, {FRAC{1'b0}}};
          end
        end
        DIV: begin
          rem_q <= RW'(ge ? rem_sh - den_u : rem_sh);
          quo_q <= {quo_q[DIVC-2:0], ge};
          dvd_q <= {dvd_q[DIVC-2:0], 1'b0};
          dc_q  <= dc_q + CW'(1);
        end
        UPD: begin
          m_q   <= m_upd;
          it_q  <= it_inc;
          k_q   <= '0;
          rr_q  <= '0;
          num_q <= '0;
          den_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != FIN);
  assign done      = (state_q == FIN);
  assign m_out     = m_q;
  assign iter_cnt  = it_q;
  assign zero_den  = zd_q;
  assign rnorm     = rnorm_q;
  assign fsm_state = state_q;

endmodule
